// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared definitions for the 4x4 keypad path. Holds the key
//                event FSM state encoding, the key-code constants, the FIFO
//                entry layout and the one-cold decode helpers. The scanner
//                test bench reuses these helpers.
//  Contents    : ST_*            FSM state encodings (2 bits)
//                KEY_*           non-digit key codes
//                onecold_t       {valid, index} result of a one-cold decode
//                key_event_t     {long_press, code} FIFO entry
//                onecold_to_index()  one-cold vector -> index + valid
//                key_code()          (row, col) -> 4-bit key code
//  Revision    : 1.0  initial release
// ============================================================================
package keypad_pkg;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE     = 2'd1;
    localparam logic [1:0] ST_HELD         = 2'd2;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    typedef struct packed {
        logic       valid;
        logic [1:0] index;
    } onecold_t;

    typedef struct packed {
        logic       long_press;
        logic [3:0] code;
    } key_event_t;

    // Position of the single 0; anything other than exactly one 0 is invalid.
    function automatic onecold_t onecold_to_index(input logic [3:0] vec);
        onecold_t res;
        res.valid = 1'b1;
        res.index = 2'd0;
        case (vec)
            4'b1110: res.index = 2'd0;
            4'b1101: res.index = 2'd1;
            4'b1011: res.index = 2'd2;
            4'b0111: res.index = 2'd3;
            default: res.valid = 1'b0;
        endcase
        return res;
    endfunction

    // Keypad face: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
    function automatic logic [3:0] key_code(input logic [1:0] row,
                                            input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'd1;
            4'h1: code = 4'd2;
            4'h2: code = 4'd3;
            4'h3: code = KEY_A;
            4'h4: code = 4'd4;
            4'h5: code = 4'd5;
            4'h6: code = 4'd6;
            4'h7: code = KEY_B;
            4'h8: code = 4'd7;
            4'h9: code = 4'd8;
            4'hA: code = 4'd9;
            4'hB: code = KEY_C;
            4'hC: code = KEY_STAR;
            4'hD: code = 4'd0;
            4'hE: code = KEY_HASH;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_fifo
//  Description : Small synchronous FIFO for key events with a sticky overflow
//                flag. A push into a full FIFO is accepted only when a pop
//                frees a slot in the same cycle; otherwise it is dropped.
//  Ports       : key_clk    clock, posedge
//                rst        asynchronous active-low reset
//                push       write request, push_data is the entry
//                pop        read request (ignored while empty)
//                pop_data   head entry, 0 while empty
//                empty/full/count  occupancy
//                overflow   sticky, set when a push is dropped
//  Revision    : 1.0  initial release
// ============================================================================
module key_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic                         key_clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == COUNT_W'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem[head];

    // Storage needs no reset: the output is masked while empty.
    always_ff @(posedge key_clk) begin
        if (do_push) begin
            mem[tail] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer wrap is natural overflow.
    always_ff @(posedge key_clk or negedge rst) begin
        if (!rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                tail <= tail + PTR_W'(1);
            end
            if (do_pop) begin
                head <= head + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + COUNT_W'(1);
                2'b01:   count <= count - COUNT_W'(1);
                default: count <= count;
            endcase
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_decoder
//  Description : Turns debounced keypad presses into key-code events, with one
//                extra long-press event per hold, buffered in a FIFO with a
//                valid/ready output handshake.
//  Ports       : key_clk           scan clock, posedge
//                rst               asynchronous active-low reset
//                key_pressed_flag  1 while the scanner holds a captured key
//                col_val/row_val   one-cold captured column / row
//                ev_ready          downstream accepts head event
//                ev_valid/ev_code/ev_long  head event
//                ev_count          FIFO occupancy
//                err_multi         pulse: accepted press not decodable
//                overflow          sticky: event dropped on full FIFO
//  Revision    : 1.0  initial release
// ============================================================================
module key_event_decoder
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE    = 3,
    parameter int LONG_CYCLES = 400,
    parameter int DEPTH       = 4
) (
    input  logic                       key_clk,
    input  logic                       rst,
    input  logic                       key_pressed_flag,
    input  logic [3:0]                 col_val,
    input  logic [3:0]                 row_val,
    input  logic                       ev_ready,
    output logic                       ev_valid,
    output logic [3:0]                 ev_code,
    output logic                       ev_long,
    output logic [$clog2(DEPTH+1)-1:0] ev_count,
    output logic                       err_multi,
    output logic                       overflow
);

    localparam int              CNT_W      = $clog2(LONG_CYCLES+1);
    localparam logic [CNT_W-1:0] DEB_LIMIT  = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] LONG_LIMIT = CNT_W'(LONG_CYCLES-1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [3:0]       code_latch;
    logic [3:0]       code_nxt;
    logic             armed;

    onecold_t         col_dec;
    onecold_t         row_dec;
    logic             decode_valid;
    logic [3:0]       decode_code;

    logic             push;
    key_event_t       push_data;
    key_event_t       head_data;
    logic             fifo_empty;
    logic             fifo_full;

    assign col_dec      = onecold_to_index(col_val);
    assign row_dec      = onecold_to_index(row_val);
    assign decode_valid = col_dec.valid & row_dec.valid;
    assign decode_code  = key_code(row_dec.index, col_dec.index);

    // armed stays low after reset until the flag is seen low, so a key that
    // was held across reset cannot start a new press.
    always_ff @(posedge key_clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            code_latch <= 4'd0;
            armed      <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            code_latch <= code_nxt;
            if (!key_pressed_flag) begin
                armed <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        code_nxt  = code_latch;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (key_pressed_flag && armed) begin
                    state_nxt = ST_DEBOUNCE;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (!key_pressed_flag) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LIMIT) begin
                    cnt_nxt = '0;
                    if (decode_valid) begin
                        code_nxt  = decode_code;
                        state_nxt = ST_HELD;
                    end else begin
                        state_nxt = ST_WAIT_RELEASE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (!key_pressed_flag) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == LONG_LIMIT) begin
                    state_nxt = ST_WAIT_RELEASE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_nxt = '0;
                if (!key_pressed_flag) begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        push      = 1'b0;
        push_data = '0;
        err_multi = 1'b0;
        case (state)
            ST_DEBOUNCE: begin
                if (key_pressed_flag && (cnt == DEB_LIMIT)) begin
                    if (decode_valid) begin
                        push      = 1'b1;
                        push_data = '{long_press: 1'b0, code: decode_code};
                    end else begin
                        err_multi = 1'b1;
                    end
                end
            end
            ST_HELD: begin
                if (key_pressed_flag && (cnt == LONG_LIMIT)) begin
                    push      = 1'b1;
                    push_data = '{long_press: 1'b1, code: code_latch};
                end
            end
            default: begin
                push = 1'b0;
            end
        endcase
    end

    key_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (5)
    ) u_fifo (
        .key_clk   (key_clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (ev_ready),
        .pop_data  (head_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (ev_count),
        .overflow  (overflow)
    );

    assign ev_valid = ~fifo_empty;
    assign ev_code  = head_data.code;
    assign ev_long  = head_data.long_press;

endmodule
`default_nettype wire

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
Consumer side of the 4x4 keypad scan interface: reads the scanner's captured column/row strobes and its pressed flag, and turns each debounced press into a 4-bit key code event. A long hold produces one additional event tagged as long-press. Events are buffered in a small FIFO and handed to downstream logic (clock-set, alarm entry) with a valid/ready handshake. Runs in the scanner's clock domain, so no synchronisers are required.

Parameters:
DEBOUNCE, 3, consecutive key_clk cycles key_pressed_flag must stay 1 before the press is accepted (>=1)
LONG_CYCLES, 400, cycles of continuous hold after acceptance before the long-press event is emitted (>DEBOUNCE)
DEPTH, 4, FIFO entries (power of 2, >=2)

Ports:
key_clk  in  1  scan clock, all logic on posedge
rst  in  1  asynchronous, active-low reset
key_pressed_flag  in  1  1 while the scanner holds a captured key
col_val  in  4  captured column drive, one-cold (1110=col0 .. 0111=col3)
row_val  in  4  captured row sense, one-cold (1110=row0 .. 0111=row3)
ev_ready  in  1  downstream accepts head event
ev_valid  out  1  FIFO not empty
ev_code  out  4  key code of head event
ev_long  out  1  head event is a long-press event
ev_count  out  $clog2(DEPTH+1)  entries currently held
err_multi  out  1  one-cycle pulse: accepted press not decodable
overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset is rst, asynchronous, active-low; clock is key_clk. During reset: state=IDLE, counters=0, FIFO empty, ev_valid=0, ev_code=0, ev_long=0, ev_count=0, err_multi=0, overflow=0. Reset mid-hold discards the press; no event is produced after release.
- Decode (combinational from col_val/row_val): col index c, row index r, taken from the position of the single 0. Layout is row0 1 2 3 A / row1 4 5 6 B / row2 7 8 9 C / row3 * 0 # D. Codes: digits = value, A..D = 10..13, * = 14, # = 15. Decode is invalid if either vector is not exactly one-cold (1111, or more than one 0).
- FSM states: IDLE, DEBOUNCE, HELD, WAIT_RELEASE.
  - IDLE: flag=1 -> DEBOUNCE, cnt=1.
  - DEBOUNCE: flag=0 -> IDLE with no event. flag=1 and cnt==DEBOUNCE -> accept, using col_val/row_val sampled this cycle. Valid decode: push {long=0, code}, latch code, go HELD, cnt=0. Invalid decode: err_multi=1 for this cycle, no push, go WAIT_RELEASE. Otherwise cnt++.
  - HELD: flag=0 -> IDLE. cnt==LONG_CYCLES-1 -> push {long=1, latched code}, go WAIT_RELEASE. Otherwise cnt++.
  - WAIT_RELEASE: flag=0 -> IDLE. No further events from the same hold.
- Latency: the short event is visible on ev_valid (if the FIFO was empty) on the edge after the accept cycle, i.e. DEBOUNCE+1 edges after the flag is first sampled 1.
- FIFO: registered head/tail pointers plus count. ev_code/ev_long show the head entry when ev_valid=1, and hold 0 when empty. Pop when ev_valid & ev_ready.
- Push while full and no pop in the same cycle: the event is dropped and overflow is set. overflow clears only on reset.
- Push while full with a pop in the same cycle: both occur, count is unchanged, overflow is not set.
- Push and pop while empty: the push is accepted and the pop is ignored (ev_valid was 0).
- The latched code is the one captured at accept. Changes on col_val/row_val during HELD are ignored.
- Counter width is $clog2(LONG_CYCLES+1). Pointers wrap modulo DEPTH.

Decomposition:
- Shared package keypad_pkg: state encoding localparams, key-code constants (KEY_STAR=14, KEY_HASH=15, KEY_A..KEY_D), and the one-cold-to-index decode function shared with the scanner test bench.
- One sub-module: key_event_fifo (parameterised DEPTH, 5-bit data, push/pop/full/empty/count, overflow flag). The FSM and decode stay in the top level.

Test Plan:
- Flag high for 10 cycles with col_val=1101, row_val=1011 (key 8) -> one event ev_code=8, ev_long=0, ev_valid rises DEBOUNCE+1 edges after flag; nothing more on release.
- Flag high for 2 cycles then low (glitch, DEBOUNCE=3) -> no event, ev_count stays 0, err_multi stays 0.
- Hold key * (col 0111? no: col0 1110, row3 0111) for LONG_CYCLES+50 cycles, ev_ready=1 -> events {14,0} then {14,1} exactly LONG_CYCLES edges after the first push; no third event.
- col_val=1100 (two columns) held past debounce -> err_multi one-cycle pulse, no push, FSM returns to IDLE only after flag drops.
- ev_ready=0, five distinct presses with DEPTH=4 -> ev_count=4, overflow=1, popped order is the first four codes; repeat with ev_ready=1 asserted on the fifth push cycle -> no overflow.
- Assert rst low in HELD, then release rst while flag is still 1 -> all outputs 0, no long event; a new press is recognised only after the flag is seen 0 -> 1 again via IDLE.
